// File: rtl/tft_pkg.sv
// Shared TFT package: panel command bytes, default panel geometry and the
// rect-fill sequencer state encoding (also used by the byte handshake).
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int SCREEN_W_DEF = 240;
  localparam int SCREEN_H_DEF = 320;

  // header byte indices 0..10: CASET + 4 coords, RASET + 4 coords, RAMWR
  localparam logic [3:0] HDR_LAST = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_GUARD,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tft_byte_tx.sv
// Byte handshake towards tft_spi: registers byte/dc with a one-cycle strobe,
// then ignores tft_busy for one GUARD cycle (tft_spi raises busy one cycle
// late) and WAITs for it to drop. ready is combinational so a new byte can
// be strobed in the cycle right after busy falls.
module tft_byte_tx
  import tft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       dc,
  input  logic       tft_busy,
  output logic       ready,
  output logic [7:0] tft_data,
  output logic       tft_dc,
  output logic       tft_transmit
);

  state_t st;

  assign ready = !tft_busy && (st == ST_IDLE || st == ST_WAIT);

  // strobe / guard / wait sequencing; data and dc hold until the next strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= ST_IDLE;
      tft_data     <= 8'h00;
      tft_dc       <= 1'b0;
      tft_transmit <= 1'b0;
    end else begin
      tft_transmit <= 1'b0;
      case (st)
        ST_IDLE, ST_WAIT: begin
          if (ready && send) begin
            tft_data     <= data;
            tft_dc       <= dc;
            tft_transmit <= 1'b1;
            st           <= ST_GUARD;
          end else if (!tft_busy) begin
            st <= ST_IDLE;
          end
        end
        ST_GUARD: st <= ST_WAIT;
        default:  st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tft_rect_fill.sv
// Solid RGB565 rectangle fill: CASET/RASET/RAMWR header then w*h pixels,
// two bytes each, through tft_byte_tx.
// Optional clipping to the panel: define TFT_RECT_FILL_CLIP_EN.
module tft_rect_fill
  import tft_pkg::*;
#(
  parameter int COORD_W  = 9,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [15:0]        color,
  input  logic               tft_busy,
  output logic [7:0]         tft_data,
  output logic               tft_dc,
  output logic               tft_transmit,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = 2 * COORD_W;
  localparam logic [COORD_W:0] ONE_C = (COORD_W + 1)'(1);
  localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);

  state_t             st;
  logic [3:0]         idx;
  logic [COORD_W-1:0] x_r, y_r;
  logic [COORD_W:0]   x1_r, y1_r;
  logic [15:0]        color_r;
  logic [CNT_W-1:0]   cnt;

  logic [COORD_W:0]   x1_n, y1_n;
  logic [CNT_W-1:0]   area_n;
  logic               zero_n;

  logic               send, tx_dc, ready, adv;
  logic [7:0]         tx_byte;

  // far corner and pixel count from the raw request (used only on accept)
  always_comb begin
    x1_n   = {1'b0, x} + {1'b0, w} - ONE_C;
    y1_n   = {1'b0, y} + {1'b0, h} - ONE_C;
    zero_n = (w == '0) || (h == '0);
`ifdef TFT_RECT_FILL_CLIP_EN
    if ({1'b0, x} >= (COORD_W + 1)'(SCREEN_W)) zero_n = 1'b1;
    if ({1'b0, y} >= (COORD_W + 1)'(SCREEN_H)) zero_n = 1'b1;
    if (x1_n > (COORD_W + 1)'(SCREEN_W - 1)) x1_n = (COORD_W + 1)'(SCREEN_W - 1);
    if (y1_n > (COORD_W + 1)'(SCREEN_H - 1)) y1_n = (COORD_W + 1)'(SCREEN_H - 1);
    area_n = CNT_W'(x1_n - {1'b0, x} + ONE_C) * CNT_W'(y1_n - {1'b0, y} + ONE_C);
`else
    area_n = CNT_W'(w) * CNT_W'(h);
`endif
  end

  // byte to offer this cycle; the first CASET goes out straight from IDLE
  always_comb begin
    send    = 1'b0;
    tx_dc   = 1'b1;
    tx_byte = 8'h00;
    case (idx)
      4'd0:    begin tx_byte = CMD_CASET; tx_dc = 1'b0; end
      4'd1:    tx_byte = 8'(16'(x_r) >> 8);
      4'd2:    tx_byte = 8'(16'(x_r));
      4'd3:    tx_byte = 8'(16'(x1_r) >> 8);
      4'd4:    tx_byte = 8'(16'(x1_r));
      4'd5:    begin tx_byte = CMD_RASET; tx_dc = 1'b0; end
      4'd6:    tx_byte = 8'(16'(y_r) >> 8);
      4'd7:    tx_byte = 8'(16'(y_r));
      4'd8:    tx_byte = 8'(16'(y1_r) >> 8);
      4'd9:    tx_byte = 8'(16'(y1_r));
      default: begin tx_byte = CMD_RAMWR; tx_dc = 1'b0; end
    endcase
    case (st)
      ST_IDLE: begin
        send    = start && !zero_n;
        tx_byte = CMD_CASET;
        tx_dc   = 1'b0;
      end
      ST_HDR:    send = 1'b1;
      ST_PIX_HI: begin send = 1'b1; tx_byte = color_r[15:8]; tx_dc = 1'b1; end
      ST_PIX_LO: begin send = 1'b1; tx_byte = color_r[7:0];  tx_dc = 1'b1; end
      default:   send = 1'b0;
    endcase
  end

  assign adv = send && ready;

  // request sequencer; DONE first waits for the last byte, then pulses done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= ST_IDLE;
      idx     <= '0;
      x_r     <= '0;
      y_r     <= '0;
      x1_r    <= '0;
      y1_r    <= '0;
      color_r <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            x_r     <= x;
            y_r     <= y;
            x1_r    <= x1_n;
            y1_r    <= y1_n;
            color_r <= color;
            cnt     <= area_n;
            busy    <= 1'b1;
            if (zero_n) begin
              done <= 1'b1;
              st   <= ST_DONE;
            end else begin
              idx <= adv ? 4'd1 : 4'd0;
              st  <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (adv) begin
            if (idx == HDR_LAST) begin
              idx <= '0;
              st  <= ST_PIX_HI;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_PIX_HI: if (adv) st <= ST_PIX_LO;
        ST_PIX_LO: begin
          if (adv) begin
            cnt <= cnt - ONE_N;
            st  <= (cnt == ONE_N) ? ST_DONE : ST_PIX_HI;
          end
        end
        ST_DONE: begin
          if (done) begin
            done <= 1'b0;
            busy <= 1'b0;
            st   <= ST_IDLE;
          end else if (ready) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  tft_byte_tx u_tx (
    .clk          (clk),
    .rst          (rst),
    .send         (send),
    .data         (tx_byte),
    .dc           (tx_dc),
    .tft_busy     (tft_busy),
    .ready        (ready),
    .tft_data     (tft_data),
    .tft_dc       (tft_dc),
    .tft_transmit (tft_transmit)
  );

endmodule

// File: tb/tb_tft_rect_fill.sv
// Directed bench for tft_rect_fill with an 8-cycle tft_spi busy model.
module tb_tft_rect_fill;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] x = '0, y = '0, w = '0, h = '0;
  logic [15:0] color = '0;
  logic       tft_busy;
  logic [7:0] tft_data;
  logic       tft_dc, tft_transmit, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tft_rect_fill dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .w(w), .h(h),
    .color(color), .tft_busy(tft_busy), .tft_data(tft_data), .tft_dc(tft_dc),
    .tft_transmit(tft_transmit), .busy(busy), .done(done)
  );

  // tft_spi stand-in: busy for 8 cycles starting the cycle after a strobe
  int   busy_cnt;
  logic force_busy = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) busy_cnt <= 0;
    else if (tft_transmit) busy_cnt <= 8;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tft_busy = force_busy || (busy_cnt != 0);

  // recorder: strobes, done pulses, busy falls
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] log_q[$];
  int         log_cyc[$];
  int         done_cnt = 0, done_cyc = 0, fall_cyc = 0, coincide = 0;
  logic       busy_at_done = 1'b0;
  logic       busy_prev = 1'b0;
  always @(negedge clk) begin
    if (tft_transmit) begin
      log_q.push_back({tft_dc, tft_data});
      log_cyc.push_back(cyc);
      if (tft_busy) coincide++;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (busy_prev && !tft_busy) fall_cyc = cyc;
    busy_prev = tft_busy;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [8:0] px, py, pw, ph, input logic [15:0] pc,
                             output int scyc);
    x = px; y = py; w = pw; h = ph; color = pc;
    start = 1'b1;
    scyc  = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tick();
    checks++;
    if ({tft_data, tft_dc, tft_transmit, busy, done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h dc=%b tx=%b busy=%b done=%b required all 0",
               tft_data, tft_dc, tft_transmit, busy, done);
    end
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic;
    logic [8:0] exp[$];
    int base, dbase, scyc;
    bit ok;
    exp = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10B, 9'h02B, 9'h100, 9'h114,
            9'h100, 9'h114, 9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
    base = log_q.size(); dbase = done_cnt;
    pulse_start(9'd10, 9'd20, 9'd2, 9'd1, 16'hF800, scyc);
    wait_done(dbase, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_timeout: no done within 1000 cycles"); end
    repeat (12) tick();
    checks++;
    if (log_q.size() - base != 15) begin
      errors++; $display("FAIL basic_count: got %0d strobes required 15", log_q.size() - base);
    end
    for (int i = 0; i < 15 && base + i < log_q.size(); i++) begin
      checks++;
      if (log_q[base + i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got dc/data %h required %h", i, log_q[base + i], exp[i]);
      end
    end
    if (log_cyc.size() > base) begin
      checks++;
      if (log_cyc[base] != scyc + 1) begin
        errors++; $display("FAIL basic_first_latency: got cycle %0d required %0d", log_cyc[base], scyc + 1);
      end
    end
    checks++;
    if (done_cnt - dbase != 1) begin
      errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - dbase);
    end
    checks++;
    if (done_cyc != fall_cyc + 1) begin
      errors++; $display("FAIL basic_done_timing: got cycle %0d required %0d", done_cyc, fall_cyc + 1);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++; $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done);
    end
  endtask

  task automatic test_zero_area;
    int base, dbase, scyc;
    base = log_q.size(); dbase = done_cnt;
    pulse_start(9'd3, 9'd4, 9'd0, 9'd5, 16'h1234, scyc);
    checks++;
    if ({done, busy} !== 2'b11) begin
      errors++; $display("FAIL zero_next_cycle: got done=%b busy=%b required 1 1", done, busy);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL zero_after: got done=%b busy=%b required 0 0", done, busy);
    end
    repeat (20) tick();
    checks++;
    if (log_q.size() != base || done_cnt - dbase != 1) begin
      errors++;
      $display("FAIL zero_strobes: got %0d strobes %0d dones required 0 and 1",
               log_q.size() - base, done_cnt - dbase);
    end
  endtask

  task automatic test_ignore_start;
    logic [8:0] exp[$];
    int base, dbase, scyc, dummy;
    bit ok;
    exp = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02B, 9'h100, 9'h103,
            9'h100, 9'h103, 9'h02C, 9'h112, 9'h134};
    base = log_q.size(); dbase = done_cnt;
    pulse_start(9'd5, 9'd3, 9'd1, 9'd1, 16'h1234, scyc);
    repeat (20) tick();
    pulse_start(9'd100, 9'd50, 9'd3, 9'd3, 16'hFFFF, dummy);
    x = '0; y = '0; w = '0; h = '0; color = '0;
    wait_done(dbase, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_done_timeout: no done within 1000 cycles"); end
    repeat (30) tick();
    checks++;
    if (log_q.size() - base != 13 || done_cnt - dbase != 1) begin
      errors++;
      $display("FAIL ignore_count: got %0d strobes %0d dones required 13 and 1",
               log_q.size() - base, done_cnt - dbase);
    end
    for (int i = 0; i < 13 && base + i < log_q.size(); i++) begin
      checks++;
      if (log_q[base + i] !== exp[i]) begin
        errors++;
        $display("FAIL ignore_byte%0d: got dc/data %h required %h", i, log_q[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_clip;
    int base, dbase, scyc, exp_n;
    logic [8:0] exp_x1;
    bit ok;
`ifdef TFT_RECT_FILL_CLIP_EN
    exp_n = 31; exp_x1 = 9'h1EF;
`else
    exp_n = 51; exp_x1 = 9'h1F9;
`endif
    base = log_q.size(); dbase = done_cnt;
    pulse_start(9'd230, 9'd0, 9'd20, 9'd1, 16'h07E0, scyc);
    wait_done(dbase, 2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clip_done_timeout: no done within 2000 cycles"); end
    repeat (12) tick();
    checks++;
    if (log_q.size() - base != exp_n) begin
      errors++; $display("FAIL clip_count: got %0d strobes required %0d", log_q.size() - base, exp_n);
    end
    if (log_q.size() - base >= 11) begin
      checks++;
      if (log_q[base + 3] !== 9'h100 || log_q[base + 4] !== exp_x1) begin
        errors++;
        $display("FAIL clip_x1: got %h %h required 100 %h", log_q[base + 3], log_q[base + 4], exp_x1);
      end
      checks++;
      if (log_q[base + 10] !== 9'h02C || log_q[log_q.size() - 1] !== 9'h1E0) begin
        errors++;
        $display("FAIL clip_tail: got ramwr %h last %h required 02c 1e0",
                 log_q[base + 10], log_q[log_q.size() - 1]);
      end
    end
  endtask

  task automatic test_busy_hold;
    int base, dbase, scyc, rel;
    bit ok;
    base = log_q.size(); dbase = done_cnt;
    force_busy = 1'b1;
    repeat (50) tick();
    pulse_start(9'd0, 9'd0, 9'd1, 9'd1, 16'hABCD, scyc);
    repeat (5) tick();
    checks++;
    if (log_q.size() != base) begin
      errors++; $display("FAIL hold_no_strobe: got %0d strobes while busy required 0", log_q.size() - base);
    end
    force_busy = 1'b0;
    rel = cyc;
    wait_done(dbase, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_done_timeout: no done within 1000 cycles"); end
    repeat (12) tick();
    if (log_cyc.size() > base) begin
      checks++;
      if (log_cyc[base] != rel + 1) begin
        errors++; $display("FAIL hold_first_strobe: got cycle %0d required %0d", log_cyc[base], rel + 1);
      end
    end
    checks++;
    if (log_q.size() - base != 13) begin
      errors++; $display("FAIL hold_count: got %0d strobes required 13", log_q.size() - base);
    end
    checks++;
    if (coincide != 0) begin
      errors++; $display("FAIL strobe_vs_busy: got %0d strobes with tft_busy=1 required 0", coincide);
    end
  endtask

  task automatic test_reset_mid;
    int base, dbase, scyc;
    bit ok;
    base = log_q.size(); dbase = done_cnt;
    pulse_start(9'd1, 9'd1, 9'd1, 9'd2, 16'h5555, scyc);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (log_q.size() - base >= 12) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: PIX_HI byte not seen within 1000 cycles"); end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({tft_data, tft_dc, tft_transmit, busy, done} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_outputs: got data=%h dc=%b tx=%b busy=%b done=%b required all 0",
               tft_data, tft_dc, tft_transmit, busy, done);
    end
    repeat (2) tick();
    rst = 1'b1;
    base = log_q.size();
    repeat (100) tick();
    checks++;
    if (log_q.size() != base || done_cnt != dbase || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_resume: got %0d strobes %0d dones busy=%b required 0 0 0",
               log_q.size() - base, done_cnt - dbase, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_area();
    test_ignore_start();
    test_clip();
    test_busy_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
